if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V core; sits directly upstream of the IF/ID pipeline register.
- Holds the PC register and the instruction memory, with a loader write port driven by the debug unit.
- Runs a small run-control FSM (IDLE/RUN/HALT).
- Drives instruction, PC and PC+4 into IF/ID, plus the IF/ID enable and flush strobes.

Parameters:
- NB_INSTR, 32, instruction width.
- NB_PC, 32, program counter width.
- IMEM_DEPTH, 256, instruction memory depth in words; power of two. Local NB_IADDR = clog2(IMEM_DEPTH).

Ports:
- clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  start-execution pulse from debug unit
- i_stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
- i_branch_taken  in  1  branch/jump resolved taken
- i_branch_target  in  NB_PC  redirect address
- i_load_we  in  1  loader write enable
- i_load_addr  in  NB_IADDR  loader word address
- i_load_data  in  NB_INSTR  loader write data
- o_instr  out  NB_INSTR  instruction at current PC, to IF/ID
- o_pc  out  NB_PC  current PC
- o_pc_next  out  NB_PC  PC+4
- o_if_id_en  out  1  IF/ID enable
- o_flush  out  1  IF/ID flush
- o_halted  out  1  FSM in HALT
- o_state  out  2  FSM state, for debug readout
- o_fetch_cnt  out  32  count of instructions accepted by IF/ID

Behaviour:
- Reset values:
  - PC = 0, state = IDLE, o_fetch_cnt = 0, o_halted = 0.
  - o_if_id_en = 0, o_flush = 1 (combinational outputs of IDLE).
  - Instruction memory contents are NOT reset; they survive i_rst.
- Memory:
  - Asynchronous read: o_instr = mem[PC[NB_IADDR+1:2]].
  - PC[1:0] is ignored. PC beyond the depth wraps (upper bits truncated).
  - Synchronous write on i_load_we, accepted only in IDLE or HALT; ignored in RUN.
- o_pc_next = PC + 4 modulo 2^NB_PC; wraps from 0xFFFFFFFC to 0.
- States: IDLE = 0, RUN = 1, HALT = 2.
- IDLE:
  - o_if_id_en = 0, o_flush = 1; PC holds.
  - i_start -> PC <= 0, o_fetch_cnt <= 0, next state RUN.
- RUN, priority order per cycle:
  1. i_branch_taken -> PC <= target; o_flush = 1; o_if_id_en = 0. Branch wins over a simultaneous stall or halt detect, since it comes from an older instruction.
  2. i_stall -> PC holds; o_if_id_en = 0; o_flush = 0.
  3. o_instr == HALT_INSTR (0xFFFFFFFF) -> PC holds; o_flush = 1 (halt word never enters IF/ID); next state HALT.
  4. Otherwise -> PC <= PC+4; o_if_id_en = 1; o_flush = 0; o_fetch_cnt += 1 (wraps).
- HALT:
  - o_halted = 1, o_if_id_en = 0, o_flush = 1 (continuous bubbles drain the pipe). PC holds at the halt word.
  - i_start -> PC <= 0, o_fetch_cnt <= 0, next state RUN.
- i_start in RUN is ignored.
- i_rst mid-run: back to IDLE on the next edge, overriding all other inputs.
- Latency: a fetched instruction appears at the IF/ID outputs one clock after o_if_id_en is high.

Optional Feature:
- Macro: IF_STEP_EN.
- Defined:
  - Adds ports i_step_mode (1) and i_step (1).
  - In RUN with i_step_mode = 1, the normal-advance case (4) occurs only in cycles with i_step = 1.
  - Other cycles: PC holds, o_if_id_en = 0, o_flush = 1 (bubble).
  - Branch, stall and halt handling are unchanged.
- Undefined: ports absent; fetch advances every eligible cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings IF_IDLE/IF_RUN/IF_HALT;
  - HALT_INSTR = 32'hFFFFFFFF;
  - PC_RESET = 0;
  - PC_INCR = 4.
- One sub-module, instr_mem: async read, sync write, IMEM_DEPTH x NB_INSTR. The PC/FSM/counter logic stays in if_stage.

Test Plan:
- Reset and idle: reset -> o_pc = 0, o_if_id_en = 0, o_flush = 1, o_state = 0. Load 3 words at 0..2 while IDLE -> read back via PC sweep after start.
- Straight-line run: load addi at words 0..3 and 0xFFFFFFFF at word 4, pulse i_start.
  - o_pc goes 0, 4, 8, 12, 16, then holds at 16 with o_halted = 1.
  - o_fetch_cnt = 4; halt word never has o_if_id_en = 1.
- Branch over stall: at PC = 8 assert i_stall and i_branch_taken with target 0x40 together -> next o_pc = 0x40, o_flush = 1 that cycle, o_fetch_cnt unchanged.
- Stall: i_stall high for 3 cycles at PC = 4 -> o_pc stays 4, o_if_id_en = 0, o_flush = 0. Resumes at 8 after release.
- Loader gating and restart:
  - i_load_we in RUN to word 0 -> memory unchanged.
  - In HALT, write word 0 and pulse i_start -> o_pc = 0, new word on o_instr, o_fetch_cnt = 0.
- Edge cases:
  - Branch to 0xFFFFFFFC -> o_pc_next = 0, word index wraps to IMEM_DEPTH-1.
  - i_rst mid-run -> IDLE next edge, memory contents intact.
  - With IF_STEP_EN and i_step_mode = 1: 3 single-cycle i_step pulses -> exactly 3 PC advances.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: fetch FSM encodings, halt word, PC reset/increment
package cpu_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_RESET   = 32'h0000_0000;
    localparam logic [31:0] PC_INCR    = 32'd4;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-to-IF/ID bundle: instruction, PC, PC+4, enable and flush strobes
interface if_stage_if #(
    parameter int NB_INSTR = 32,
    parameter int NB_PC    = 32
);
    logic [NB_INSTR-1:0] instr;
    logic [NB_PC-1:0]    pc;
    logic [NB_PC-1:0]    pc_next;
    logic                if_id_en;
    logic                flush;

    modport master (output instr, pc, pc_next, if_id_en, flush);
    modport slave  (input  instr, pc, pc_next, if_id_en, flush);
endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory, asynchronous read and synchronous write; contents never reset
module instr_mem #(
    parameter  int NB_INSTR   = 32,
    parameter  int IMEM_DEPTH = 256,
    localparam int NB_IADDR   = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [NB_IADDR-1:0] waddr_i,
    input  logic [NB_INSTR-1:0] wdata_i,
    input  logic [NB_IADDR-1:0] raddr_i,
    output logic [NB_INSTR-1:0] rdata_o
);
    logic [NB_INSTR-1:0] mem_q [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, instruction memory, IDLE/RUN/HALT run control
// Optional single-step gating of fetch advance when IF_STEP_EN is defined.
module if_stage
    import cpu_pkg::*;
#(
    parameter  int NB_INSTR   = 32,
    parameter  int NB_PC      = 32,
    parameter  int IMEM_DEPTH = 256,
    localparam int NB_IADDR   = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [NB_PC-1:0]    i_branch_target,
    input  logic                i_load_we,
    input  logic [NB_IADDR-1:0] i_load_addr,
    input  logic [NB_INSTR-1:0] i_load_data,
`ifdef IF_STEP_EN
    input  logic                i_step_mode,
    input  logic                i_step,
`endif
    if_stage_if.master          if_id,
    output logic                o_halted,
    output logic [1:0]          o_state,
    output logic [31:0]         o_fetch_cnt
);
    if_state_e           state_q, state_d;
    logic [NB_PC-1:0]    pc_q, pc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [NB_INSTR-1:0] instr;
    logic [NB_PC-1:0]    pc_plus4;
    logic                if_id_en;
    logic                flush;
    logic                step_ok;
    logic                mem_we;

`ifdef IF_STEP_EN
    assign step_ok = !i_step_mode || i_step;
`else
    assign step_ok = 1'b1;
`endif

    // Loader writes are blocked while the core is fetching.
    assign mem_we   = i_load_we && (state_q != IF_RUN);
    assign pc_plus4 = pc_q + NB_PC'(PC_INCR);

    instr_mem #(
        .NB_INSTR   (NB_INSTR),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_instr_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (i_load_addr),
        .wdata_i (i_load_data),
        .raddr_i (pc_q[NB_IADDR+1:2]),
        .rdata_o (instr)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IF_IDLE;
            pc_q    <= NB_PC'(PC_RESET);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        if_id_en = 1'b0;
        flush    = 1'b1;
        case (state_q)
            IF_IDLE, IF_HALT: begin
                if (i_start) begin
                    state_d = IF_RUN;
                    pc_d    = NB_PC'(PC_RESET);
                    cnt_d   = '0;
                end
            end
            IF_RUN: begin
                // Branch outranks stall and halt: it comes from an older instruction.
                if (i_branch_taken) begin
                    pc_d = i_branch_target;
                end else if (i_stall) begin
                    flush = 1'b0;
                end else if (instr == NB_INSTR'(HALT_INSTR)) begin
                    state_d = IF_HALT;
                end else if (step_ok) begin
                    pc_d     = pc_plus4;
                    if_id_en = 1'b1;
                    flush    = 1'b0;
                    cnt_d    = cnt_q + 32'd1;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    assign if_id.instr    = instr;
    assign if_id.pc       = pc_q;
    assign if_id.pc_next  = pc_plus4;
    assign if_id.if_id_en = if_id_en;
    assign if_id.flush    = flush;
    assign o_halted       = (state_q == IF_HALT);
    assign o_state        = state_q;
    assign o_fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a fetch scoreboard
module tb_if_stage;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        i_load_we = 1'b0;
    logic [7:0]  i_load_addr = '0;
    logic [31:0] i_load_data = '0;
`ifdef IF_STEP_EN
    logic        i_step_mode = 1'b0;
    logic        i_step = 1'b0;
`endif
    logic        o_halted;
    logic [1:0]  o_state;
    logic [31:0] o_fetch_cnt;

    if_stage_if #(.NB_INSTR(32), .NB_PC(32)) ifid ();

    if_stage #(.NB_INSTR(32), .NB_PC(32), .IMEM_DEPTH(256)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_load_we       (i_load_we),
        .i_load_addr     (i_load_addr),
        .i_load_data     (i_load_data),
`ifdef IF_STEP_EN
        .i_step_mode     (i_step_mode),
        .i_step          (i_step),
`endif
        .if_id           (ifid),
        .o_halted        (o_halted),
        .o_state         (o_state),
        .o_fetch_cnt     (o_fetch_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0    = 32'h0010_0093;
    localparam logic [31:0] W1    = 32'h0020_0113;
    localparam logic [31:0] W2    = 32'h0030_0193;
    localparam logic [31:0] W3    = 32'h0040_0213;
    localparam logic [31:0] W16   = 32'h0050_0293;
    localparam logic [31:0] W255  = 32'h1234_5678;
    localparam logic [31:0] NEW0  = 32'h00a0_0313;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t sb[$];
    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        fetch_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // Settle, score any fetch accepted this cycle, then advance one clock.
    task automatic tick();
        fetch_t e;
        #1;
        if (ifid.if_id_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_fetch_pc", ifid.pc, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("fetch_pc", ifid.pc, e.pc);
                chk("fetch_instr", ifid.instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        i_load_we   = 1'b1;
        i_load_addr = addr;
        i_load_data = data;
        tick();
        i_load_we   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_pc", ifid.pc, 32'h0);
        chk("rst_en", 32'(ifid.if_id_en), 32'd0);
        chk("rst_flush", 32'(ifid.flush), 32'd1);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_halted", 32'(o_halted), 32'd0);
        chk("rst_cnt", o_fetch_cnt, 32'd0);

        load(8'd0, W0);
        load(8'd1, W1);
        load(8'd2, W2);
        load(8'd3, W3);
        load(8'd4, HALTW);
        load(8'd16, W16);
        load(8'd255, W255);
        chk("idle_pc_hold", ifid.pc, 32'h0);
        chk("idle_state", 32'(o_state), 32'd0);

        // Straight-line run into the halt word
        push(32'd0, W0);
        push(32'd4, W1);
        push(32'd8, W2);
        push(32'd12, W3);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("run_state", 32'(o_state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("run_pc", ifid.pc, 32'(4 * i));
            tick();
        end
        #1;
        chk("halt_word_pc", ifid.pc, 32'd16);
        chk("halt_word_instr", ifid.instr, HALTW);
        chk("halt_word_en", 32'(ifid.if_id_en), 32'd0);
        chk("halt_word_flush", 32'(ifid.flush), 32'd1);
        tick();
        chk("halt_state", 32'(o_state), 32'd2);
        chk("halt_flag", 32'(o_halted), 32'd1);
        chk("halt_cnt", o_fetch_cnt, 32'd4);
        tick();
        chk("halt_pc_hold", ifid.pc, 32'd16);
        chk("halt_flush", 32'(ifid.flush), 32'd1);

        // Restart from HALT, then stall at PC=4
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("restart_pc", ifid.pc, 32'd0);
        chk("restart_cnt", o_fetch_cnt, 32'd0);
        push(32'd0, W0);
        tick();
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", ifid.pc, 32'd4);
            chk("stall_en", 32'(ifid.if_id_en), 32'd0);
            chk("stall_flush", 32'(ifid.flush), 32'd0);
            tick();
        end
        i_stall = 1'b0;
        push(32'd4, W1);
        tick();
        chk("stall_resume_pc", ifid.pc, 32'd8);
        chk("stall_resume_cnt", o_fetch_cnt, 32'd2);

        // Branch together with stall at PC=8
        i_stall         = 1'b1;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h40;
        #1;
        chk("br_stall_flush", 32'(ifid.flush), 32'd1);
        chk("br_stall_en", 32'(ifid.if_id_en), 32'd0);
        tick();
        i_stall        = 1'b0;
        i_branch_taken = 1'b0;
        chk("br_pc", ifid.pc, 32'h40);
        chk("br_cnt", o_fetch_cnt, 32'd2);
        chk("br_instr", ifid.instr, W16);

        // Loader write in RUN is dropped; branch to the top of the address space
        i_load_we       = 1'b1;
        i_load_addr     = 8'd0;
        i_load_data     = 32'hDEAD_BEEF;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'hFFFF_FFFC;
        tick();
        i_load_we = 1'b0;
        chk("wrap_pc", ifid.pc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", ifid.pc_next, 32'h0);
        chk("wrap_instr", ifid.instr, W255);
        i_branch_target = 32'h0;
        tick();
        chk("run_load_ignored", ifid.instr, W0);
        i_branch_target = 32'd16;
        tick();
        i_branch_taken = 1'b0;
        chk("rehalt_instr", ifid.instr, HALTW);
        tick();
        chk("rehalt_state", 32'(o_state), 32'd2);

        // Load in HALT, restart
        load(8'd0, NEW0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("halt_load_pc", ifid.pc, 32'd0);
        chk("halt_load_instr", ifid.instr, NEW0);
        chk("halt_load_cnt", o_fetch_cnt, 32'd0);
        push(32'd0, NEW0);
        tick();
        chk("post_restart_pc", ifid.pc, 32'd4);
        chk("post_restart_cnt", o_fetch_cnt, 32'd1);

        // Reset mid-run keeps memory
        push(32'd4, W1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst_state", 32'(o_state), 32'd0);
        chk("midrst_pc", ifid.pc, 32'd0);
        chk("midrst_cnt", o_fetch_cnt, 32'd0);
        chk("midrst_en", 32'(ifid.if_id_en), 32'd0);
        chk("midrst_flush", 32'(ifid.flush), 32'd1);
        chk("midrst_mem", ifid.instr, NEW0);

`ifdef IF_STEP_EN
        i_step_mode = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("step_idle_pc", ifid.pc, 32'(4 * k));
            chk("step_idle_en", 32'(ifid.if_id_en), 32'd0);
            chk("step_idle_flush", 32'(ifid.flush), 32'd1);
            tick();
            push(32'(4 * k), (k == 0) ? NEW0 : (k == 1) ? W1 : W2);
            i_step = 1'b1;
            tick();
            i_step = 1'b0;
        end
        chk("step_pc", ifid.pc, 32'd12);
        chk("step_cnt", o_fetch_cnt, 32'd3);
        tick();
        chk("step_pc_hold", ifid.pc, 32'd12);
        i_step_mode = 1'b0;
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
